wqe_ptr_table: RTL
==================

WQE_PTR_TABLE -- requirements
Module: wqe_ptr_table

Interface
REQ-001 SHALL have parameter WQE_INDEX_WIDTH, default 10, WQE id width; the table holds 2^WQE_INDEX_WIDTH entries.
REQ-002 SHALL have parameter WQE_SOURCE_LENGTH, default 11, pointer width.
REQ-003 SHALL have port sys_clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port sys_rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports s_axis_Pallocate_valid in 1, s_axis_Pallocate_id in WQE_INDEX_WIDTH, s_axis_Pallocate_ptr in WQE_SOURCE_LENGTH, s_axis_Pallocate_ready out 1: the id/ptr grant from the allocator.
REQ-006 SHALL have ports s_axis_Lookup_valid in 1, s_axis_Lookup_id in WQE_INDEX_WIDTH, s_axis_Lookup_ready out 1: the lookup request.
REQ-007 SHALL have ports m_axis_Lookup_valid out 1, m_axis_Lookup_ptr out WQE_SOURCE_LENGTH, m_axis_Lookup_hit out 1, m_axis_Lookup_ready in 1: the lookup response.
REQ-008 SHALL have ports s_axis_Complete_valid in 1, s_axis_Complete_id in WQE_INDEX_WIDTH, s_axis_Complete_ready out 1: WQE done, free its buffer.
REQ-009 SHALL have ports m_axis_Brelease_valid out 1, m_axis_Brelease_ptr out WQE_SOURCE_LENGTH, m_axis_Brelease_ready in 1: buffer release to the allocator.
REQ-010 SHALL have ports occupancy out WQE_INDEX_WIDTH+1 (count of valid entries), err_double_alloc out 1, err_bad_complete out 1 (one-cycle error pulses).

Function
REQ-011 SHALL hold one entry per id: ptr[WQE_SOURCE_LENGTH-1:0] plus a valid bit.
REQ-012 SHALL drive s_axis_Pallocate_ready = 1 except when FSM is in CLEAR and s_axis_Pallocate_id == latched completion id.
REQ-013 SHALL, on an allocate handshake to an invalid entry, write ptr, set valid, and increment occupancy in that same edge.
REQ-014 SHALL, on an allocate handshake to a valid entry, leave the entry unchanged and pulse err_double_alloc for one cycle.
REQ-015 SHALL drive s_axis_Lookup_ready = !m_axis_Lookup_valid || m_axis_Lookup_ready.
REQ-016 SHALL return a lookup one cycle after its handshake: m_axis_Lookup_valid=1, ptr=entry ptr, hit=entry valid (ptr=0 when hit=0); the response holds stable until m_axis_Lookup_ready.
REQ-017 SHALL return, for a lookup sampled in the same cycle as a write/clear of that id, the pre-edge entry contents.
REQ-018 SHALL run a completion FSM with states IDLE, CLEAR, RELEASE; s_axis_Complete_ready = 1 only in IDLE.
REQ-019 SHALL, in IDLE on a completion handshake, latch id and go to CLEAR.
REQ-020 SHALL, in CLEAR with the entry valid, clear valid, decrement occupancy, load m_axis_Brelease_ptr with the entry ptr, assert m_axis_Brelease_valid, and go to RELEASE.
REQ-021 SHALL, in CLEAR with the entry invalid, pulse err_bad_complete, issue no release, and return to IDLE.
REQ-022 SHALL, in RELEASE, hold m_axis_Brelease_valid/ptr stable until m_axis_Brelease_ready, then deassert and return to IDLE (minimum 3 cycles per completion).
REQ-023 SHALL leave occupancy unchanged when an allocate-set and a CLEAR-decrement occur in the same cycle on different ids.
REQ-024 SHALL saturate occupancy at 0 and at 2^WQE_INDEX_WIDTH; the invariant holds by construction, so saturation is never reached in legal traffic.

Reset
REQ-025 SHALL, while sys_rst=1, asynchronously clear all valid bits, go to IDLE, and drive occupancy=0, m_axis_Lookup_valid=0, m_axis_Lookup_hit=0, m_axis_Lookup_ptr=0, m_axis_Brelease_valid=0, m_axis_Brelease_ptr=0, and both error pulses 0.
REQ-026 SHALL discard any in-flight completion or lookup on reset assertion; no release is issued after reset deasserts.
REQ-027 SHALL leave ptr storage unreset; only valid bits are reset.

Structure
REQ-028 SHALL take WQE_INDEX_WIDTH, WQE_SOURCE_LENGTH defaults and FSM state encodings from the shared wqe_pool_defs header used by the resource_pool blocks.
REQ-029 SHALL be one flat module with no sub-modules; the ptr array is an inferable register or RAM array with one write port and two read ports (lookup, CLEAR).

Verification
REQ-030 Allocate id=5 ptr=0x123, lookup id=5 -> next cycle hit=1 ptr=0x123, occupancy=1.
REQ-031 Complete id=5 with m_axis_Brelease_ready held 0 for 4 cycles -> Brelease_valid=1 ptr=0x123 held stable 4 cycles; after the handshake, lookup id=5 gives hit=0 and occupancy=0.
REQ-032 Allocate id=7 twice (ptr 0x10 then 0x20) -> err_double_alloc one pulse; lookup id=7 gives 0x10.
REQ-033 Complete id=9 with no entry -> err_bad_complete one pulse, no Brelease_valid, Complete_ready back to 1 within 2 cycles.
REQ-034 With id=3 valid, complete id=3 while allocate id=3 presented during CLEAR -> Pallocate_ready=0 that cycle; the allocate is accepted next cycle with no error, occupancy ends at 1.
REQ-035 Assert sys_rst mid-RELEASE -> Brelease_valid drops immediately, occupancy=0, all lookups miss after reset.

Source files
------------

// File: rtl/wqe_pool_defs.sv
// Shared resource_pool definitions: default WQE table geometry and completion FSM encoding.
package wqe_pool_defs;

    localparam int WQE_INDEX_WIDTH_DEF   = 10;
    localparam int WQE_SOURCE_LENGTH_DEF = 11;

    typedef enum logic [1:0] {
        CPL_IDLE    = 2'd0,
        CPL_CLEAR   = 2'd1,
        CPL_RELEASE = 2'd2
    } cpl_state_t;

endpackage

// File: rtl/wqe_ptr_table.sv
// WQE id -> source buffer pointer table: allocator writes, registered lookups,
// and a completion FSM that invalidates an entry and returns its buffer.
module wqe_ptr_table
    import wqe_pool_defs::*;
#(
    parameter int WQE_INDEX_WIDTH   = WQE_INDEX_WIDTH_DEF,
    parameter int WQE_SOURCE_LENGTH = WQE_SOURCE_LENGTH_DEF
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,

    input  logic                         s_axis_Pallocate_valid,
    input  logic [WQE_INDEX_WIDTH-1:0]   s_axis_Pallocate_id,
    input  logic [WQE_SOURCE_LENGTH-1:0] s_axis_Pallocate_ptr,
    output logic                         s_axis_Pallocate_ready,

    input  logic                         s_axis_Lookup_valid,
    input  logic [WQE_INDEX_WIDTH-1:0]   s_axis_Lookup_id,
    output logic                         s_axis_Lookup_ready,

    output logic                         m_axis_Lookup_valid,
    output logic [WQE_SOURCE_LENGTH-1:0] m_axis_Lookup_ptr,
    output logic                         m_axis_Lookup_hit,
    input  logic                         m_axis_Lookup_ready,

    input  logic                         s_axis_Complete_valid,
    input  logic [WQE_INDEX_WIDTH-1:0]   s_axis_Complete_id,
    output logic                         s_axis_Complete_ready,

    output logic                         m_axis_Brelease_valid,
    output logic [WQE_SOURCE_LENGTH-1:0] m_axis_Brelease_ptr,
    input  logic                         m_axis_Brelease_ready,

    output logic [WQE_INDEX_WIDTH:0]     occupancy,
    output logic                         err_double_alloc,
    output logic                         err_bad_complete
);

    localparam int DEPTH = 1 << WQE_INDEX_WIDTH;
    localparam logic [WQE_INDEX_WIDTH:0] OCC_FULL = {1'b1, {WQE_INDEX_WIDTH{1'b0}}};

    logic [WQE_SOURCE_LENGTH-1:0] ptr_mem [DEPTH];
    logic [DEPTH-1:0]             valid_q;

    cpl_state_t                   state;
    cpl_state_t                   state_next;
    logic [WQE_INDEX_WIDTH-1:0]   cpl_id;

    logic                         alloc_fire;
    logic                         alloc_set;
    logic                         alloc_dup;
    logic                         lookup_fire;
    logic                         cpl_fire;
    logic                         clear_hit;
    logic                         clear_miss;
    logic [WQE_SOURCE_LENGTH-1:0] clear_ptr;

    // Blocking an allocate to the id under CLEAR keeps set and clear on distinct entries.
    assign s_axis_Pallocate_ready = !((state == CPL_CLEAR) && (s_axis_Pallocate_id == cpl_id));
    assign alloc_fire  = s_axis_Pallocate_valid && s_axis_Pallocate_ready;
    assign alloc_set   = alloc_fire && !valid_q[s_axis_Pallocate_id];
    assign alloc_dup   = alloc_fire &&  valid_q[s_axis_Pallocate_id];

    assign s_axis_Lookup_ready   = !m_axis_Lookup_valid || m_axis_Lookup_ready;
    assign lookup_fire           = s_axis_Lookup_valid && s_axis_Lookup_ready;

    assign s_axis_Complete_ready = (state == CPL_IDLE);
    assign cpl_fire              = s_axis_Complete_valid && s_axis_Complete_ready;
    assign m_axis_Brelease_valid = (state == CPL_RELEASE);
    assign clear_ptr             = ptr_mem[cpl_id];

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        clear_hit  = 1'b0;
        clear_miss = 1'b0;
        case (state)
            CPL_IDLE: begin
                if (s_axis_Complete_valid) state_next = CPL_CLEAR;
            end
            CPL_CLEAR: begin
                if (valid_q[cpl_id]) begin
                    clear_hit  = 1'b1;
                    state_next = CPL_RELEASE;
                end else begin
                    clear_miss = 1'b1;
                    state_next = CPL_IDLE;
                end
            end
            CPL_RELEASE: begin
                if (m_axis_Brelease_ready) state_next = CPL_IDLE;
            end
            default: state_next = CPL_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state  <= CPL_IDLE;
            cpl_id <= '0;
        end else begin
            state <= state_next;
            if (cpl_fire) cpl_id <= s_axis_Complete_id;
        end
    end

    // NOTE: pointer storage is deliberately not reset; the valid bits alone qualify it.
    always_ff @(posedge sys_clk) begin
        if (alloc_set) ptr_mem[s_axis_Pallocate_id] <= s_axis_Pallocate_ptr;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            valid_q <= '0;
        end else begin
            if (alloc_set) valid_q[s_axis_Pallocate_id] <= 1'b1;
            if (clear_hit) valid_q[cpl_id]              <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            occupancy <= '0;
        end else begin
            case ({alloc_set, clear_hit})
                2'b10:   if (occupancy != OCC_FULL) occupancy <= occupancy + 1'b1;
                2'b01:   if (occupancy != '0)       occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            err_double_alloc    <= 1'b0;
            err_bad_complete    <= 1'b0;
            m_axis_Brelease_ptr <= '0;
        end else begin
            err_double_alloc <= alloc_dup;
            err_bad_complete <= clear_miss;
            if (clear_hit) m_axis_Brelease_ptr <= clear_ptr;
        end
    end

    // Response captures pre-edge entry contents, so a same-cycle write/clear is not visible.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            m_axis_Lookup_valid <= 1'b0;
            m_axis_Lookup_hit   <= 1'b0;
            m_axis_Lookup_ptr   <= '0;
        end else if (lookup_fire) begin
            m_axis_Lookup_valid <= 1'b1;
            m_axis_Lookup_hit   <= valid_q[s_axis_Lookup_id];
            m_axis_Lookup_ptr   <= valid_q[s_axis_Lookup_id] ? ptr_mem[s_axis_Lookup_id] : '0;
        end else if (m_axis_Lookup_ready) begin
            m_axis_Lookup_valid <= 1'b0;
        end
    end

endmodule
